// File: rtl/irrigation_zone_controller.sv
// Multi-zone irrigation scheduler: round-robin zone watering, tank refill with hysteresis.
// Optional fill watchdog (sticky ALARM) enabled by defining IRRIGATION_FILL_WATCHDOG_EN.
module irrigation_zone_controller #(
  parameter int ZONES       = 2,
  parameter int LEVEL_W     = 3,
  parameter int LOW_LEVEL   = 1,
  parameter int HIGH_LEVEL  = 6,
  parameter int DWELL_TICKS = 8,
  parameter int FILL_TICKS  = 32,
  parameter int TIMER_W     = 8,
  localparam int ZW         = (ZONES > 1) ? $clog2(ZONES) : 1
) (
  input  logic               clock,
  input  logic               reset_pulse,
  input  logic               tick,
  input  logic [LEVEL_W-1:0] water_level,
  input  logic [ZONES-1:0]   zone_request,
  input  logic [ZONES-1:0]   zone_mode,
  output logic               filling,
  output logic [ZONES-1:0]   sprinkler,
  output logic [ZONES-1:0]   dripper,
  output logic [ZW-1:0]      active_zone,
  output logic [1:0]         state,
  output logic               alarm
);

  localparam logic [1:0] S_IDLE     = 2'b00;
  localparam logic [1:0] S_WATERING = 2'b01;
  localparam logic [1:0] S_FILLING  = 2'b10;
  localparam logic [1:0] S_ALARM    = 2'b11;

  localparam logic [LEVEL_W-1:0] LOW_C     = LEVEL_W'(LOW_LEVEL);
  localparam logic [LEVEL_W-1:0] HIGH_C    = LEVEL_W'(HIGH_LEVEL);
  localparam logic [TIMER_W-1:0] DWELL_C   = TIMER_W'(DWELL_TICKS);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
  localparam logic [ZW:0]        ZONES_C   = (ZW+1)'(ZONES);
  localparam logic [ZW-1:0]      LAST_ZONE = ZW'(ZONES - 1);
`ifdef IRRIGATION_FILL_WATCHDOG_EN
  localparam logic [TIMER_W-1:0] FILL_LOAD = TIMER_W'(FILL_TICKS);
`else
  localparam logic [TIMER_W-1:0] FILL_LOAD = '0;
`endif

  if (HIGH_LEVEL <= LOW_LEVEL) begin : g_bad_thresholds
    $error("HIGH_LEVEL must be greater than LOW_LEVEL");
  end
  if (DWELL_TICKS < 1 || DWELL_TICKS >= 2**TIMER_W) begin : g_bad_dwell
    $error("DWELL_TICKS out of range for TIMER_W");
  end
  if (FILL_TICKS < 1 || FILL_TICKS >= 2**TIMER_W) begin : g_bad_fill
    $error("FILL_TICKS out of range for TIMER_W");
  end

  logic [1:0]         state_q, state_d;
  logic [ZW-1:0]      ptr_q, ptr_d;
  logic [ZW-1:0]      active_q, active_d;
  logic               mode_q, mode_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  logic               level_low, level_high, timer_last, req_active;
  logic [ZW-1:0]      next_ptr;
  logic [ZONES-1:0]   req_rot;
  logic               grant_found;
  logic [ZW-1:0]      grant_idx;
  logic [ZW:0]        grant_sum;

  assign level_low  = (water_level <= LOW_C);
  assign level_high = (water_level >= HIGH_C);
  assign timer_last = tick && (timer_q == TIMER_ONE);
  assign req_active = zone_request[active_q];
  assign next_ptr   = (active_q == LAST_ZONE) ? '0 : active_q + 1'b1;

  // Rotate so bit 0 is the pointer zone; the lowest set bit is the next grant.
  assign req_rot = ZONES'({zone_request, zone_request} >> ptr_q);

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_sum   = '0;
    for (int i = ZONES - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        grant_found = 1'b1;
        grant_sum   = {1'b0, ptr_q} + (ZW+1)'(i);
        grant_idx   = (grant_sum >= ZONES_C) ? ZW'(grant_sum - ZONES_C) : ZW'(grant_sum);
      end
    end
  end

  // NOTE: every next-state signal is defaulted to its register first, so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    active_d = active_q;
    mode_d   = mode_q;
    timer_d  = timer_q;
    case (state_q)
      S_IDLE: begin
        if (level_low) begin
          state_d = S_FILLING;
          timer_d = FILL_LOAD;
        end else if (grant_found) begin
          state_d  = S_WATERING;
          active_d = grant_idx;
          mode_d   = zone_mode[grant_idx];
          timer_d  = DWELL_C;
        end
      end
      S_WATERING: begin
        if (level_low) begin
          state_d = S_FILLING;
          timer_d = FILL_LOAD;
          ptr_d   = next_ptr;
        end else if (timer_last || !req_active) begin
          state_d = S_IDLE;
          ptr_d   = next_ptr;
        end else if (tick) begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_FILLING: begin
        if (level_high) begin
          state_d = S_IDLE;
`ifdef IRRIGATION_FILL_WATCHDOG_EN
        end else if (timer_last) begin
          state_d = S_ALARM;
        end else if (tick) begin
          timer_d = timer_q - 1'b1;
`endif
        end
      end
      default: state_d = S_ALARM;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset_pulse) begin
    if (reset_pulse) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      active_q <= '0;
      mode_q   <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      active_q <= active_d;
      mode_q   <= mode_d;
      timer_q  <= timer_d;
    end
  end

  // Moore decode of registered state only, so reset clears every valve with no glitch path.
  always_comb begin
    sprinkler = '0;
    dripper   = '0;
    for (int i = 0; i < ZONES; i++) begin
      sprinkler[i] = (state_q == S_WATERING) &&  mode_q && (active_q == ZW'(i));
      dripper[i]   = (state_q == S_WATERING) && !mode_q && (active_q == ZW'(i));
    end
  end

  assign filling     = (state_q == S_FILLING);
  assign active_zone = active_q;
  assign state       = state_q;
`ifdef IRRIGATION_FILL_WATCHDOG_EN
  assign alarm = (state_q == S_ALARM);
`else
  assign alarm = 1'b0;
`endif

endmodule
